// File: rtl/riscv_icache_pkg.sv
// Shared widths, FSM encoding and address-field helpers for the I-cache controller.
package riscv_icache_pkg;

  localparam int DATA_WIDTH  = 128;
  localparam int CACHE_SIZE  = 4 * (2 ** 10);
  localparam int MEM_SIZE    = 4 * CACHE_SIZE;
  localparam int DATAPBLOCK  = 16;
  localparam int CACHE_DEPTH = CACHE_SIZE / DATAPBLOCK;
  localparam int ADDR        = $clog2(MEM_SIZE);
  localparam int BYTE_OFF    = $clog2(DATAPBLOCK);
  localparam int INDEX       = $clog2(CACHE_DEPTH);
  localparam int TAG         = ADDR - BYTE_OFF - INDEX;
  localparam int S_ADDR      = ADDR - BYTE_OFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALLOCATE = 2'd1,
    REFILL   = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  // Latched miss; {tag, idx} is also the block address sent to memory.
  typedef struct packed {
    logic [TAG-1:0]   tag;
    logic [INDEX-1:0] idx;
  } miss_t;

  function automatic logic [TAG-1:0] tag_of(input logic [ADDR-1:0] a);
    return a[ADDR-1 -: TAG];
  endfunction

  function automatic logic [INDEX-1:0] index_of(input logic [ADDR-1:0] a);
    return a[BYTE_OFF +: INDEX];
  endfunction

  function automatic logic [S_ADDR-1:0] block_of(input logic [ADDR-1:0] a);
    return a[ADDR-1:BYTE_OFF];
  endfunction

endpackage

// File: rtl/riscv_icache_ctrl_if.sv
// Fetch, memory-refill and data-array signals of the I-cache controller.
interface riscv_icache_ctrl_if;
  import riscv_icache_pkg::*;

  logic                  cpu_req;
  logic [ADDR-1:0]       cpu_addr;
  logic                  flush;
  logic                  cpu_stall;
  logic                  mem_rden;
  logic [S_ADDR-1:0]     mem_addr;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  cache_wren;
  logic [INDEX-1:0]      cache_index;
  logic [DATA_WIDTH-1:0] cache_wdata;

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_ready, mem_data,
    output cpu_stall, mem_rden, mem_addr, cache_wren, cache_index, cache_wdata
  );

  modport master (
    output cpu_req, cpu_addr, flush, mem_ready, mem_data,
    input  cpu_stall, mem_rden, mem_addr, cache_wren, cache_index, cache_wdata
  );

endinterface

// File: rtl/riscv_icache_tag_array.sv
// Tag + valid storage: one write port, one clear port for the flush sweep, comb hit.
module riscv_icache_tag_array
  import riscv_icache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [INDEX-1:0] rd_index,
  input  logic [TAG-1:0]   rd_tag,
  output logic             hit,
  input  logic             wr_en,
  input  logic [INDEX-1:0] wr_index,
  input  logic [TAG-1:0]   wr_tag,
  input  logic             clr_en,
  input  logic [INDEX-1:0] clr_index
);

  logic [CACHE_DEPTH-1:0] valid;
  logic [TAG-1:0]         tags [CACHE_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         valid <= '0;
    else if (clr_en) valid[clr_index] <= 1'b0;
    else if (wr_en)  valid[wr_index]  <= 1'b1;
  end

  // Tags need no reset: every entry is gated by its valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) tags[wr_index] <= wr_tag;
  end

  assign hit = valid[rd_index] && (tags[rd_index] == rd_tag);

endmodule

// File: rtl/riscv_icache_ctrl.sv
// Direct-mapped I-cache controller: zero-cycle hit, blocking refill, full valid sweep on flush.
module riscv_icache_ctrl
  import riscv_icache_pkg::*;
(
  input logic               clk,
  input logic               rst,
  riscv_icache_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_ALLOCATE = ALLOCATE;
  localparam logic [1:0] S_REFILL   = REFILL;
  localparam logic [1:0] S_FLUSH    = FLUSH;

  logic [1:0]            state;
  miss_t                 miss_q;
  logic [INDEX-1:0]      sweep_cnt;
  logic                  flush_pending;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  hit;
  logic [INDEX-1:0]      cpu_idx;
  logic [TAG-1:0]        cpu_tag;

  assign cpu_idx = index_of(bus.cpu_addr);
  assign cpu_tag = tag_of(bus.cpu_addr);

  riscv_icache_tag_array u_tags (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (cpu_idx),
    .rd_tag    (cpu_tag),
    .hit       (hit),
    .wr_en     (state == S_REFILL),
    .wr_index  (miss_q.idx),
    .wr_tag    (miss_q.tag),
    .clr_en    (state == S_FLUSH),
    .clr_index (sweep_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      miss_q        <= '0;
      sweep_cnt     <= '0;
      flush_pending <= 1'b0;
      wdata_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Flush beats a concurrent miss; the fetch re-looks-up after the sweep.
          if (bus.flush) begin
            state <= S_FLUSH;
          end else if (bus.cpu_req && !hit) begin
            miss_q <= '{tag: cpu_tag, idx: cpu_idx};
            state  <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          if (bus.flush) flush_pending <= 1'b1;
          if (bus.mem_ready) begin
            wdata_q <= bus.mem_data;
            state   <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (bus.flush) flush_pending <= 1'b1;
          state <= (flush_pending || bus.flush) ? S_FLUSH : S_IDLE;
        end
        S_FLUSH: begin
          // Counter wraps to 0 on exit, ready for the next sweep.
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == INDEX'(CACHE_DEPTH - 1)) begin
            flush_pending <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_stall   = !rst && ((state != S_IDLE) || (bus.cpu_req && !hit));
  assign bus.mem_rden    = (state == S_ALLOCATE);
  assign bus.mem_addr    = {miss_q.tag, miss_q.idx};
  assign bus.cache_wren  = (state == S_REFILL);
  assign bus.cache_index = (state == S_REFILL) ? miss_q.idx : cpu_idx;
  assign bus.cache_wdata = wdata_q;

endmodule
